// File: rtl/defines_pkg.sv
// defines_pkg
// Shared sizing constants for the forwarding register file: address width,
// data width and the number of forwarding stages per pipe (s2..s7).
package defines_pkg;

  localparam int REG_ADDR_WD = 7;
  localparam int REG_DATA_WD = 128;
  localparam int NUM_FWD     = 6;

endpackage

// File: rtl/reg_file_fwd_if.sv
// reg_file_fwd_if
// Bundles the operand-read, writeback and forwarding signals of reg_file_fwd.
//   master : pipeline side, drives requests/writes/forwarding, sees results
//   slave  : register file side
// Signals:
//   rd_valid, ra/rb/rc_addr         operand read request
//   ev_/od_wr_en/addr/data          even/odd writeback ports
//   ev_/od_fwd_vld/addr/data        per-stage forwarding (bit/slice 0 = s2)
//   out_RA/RB/RC, out_vld           resolved operands, one cycle later
//   wr_collision                    dual write to one address last cycle
interface reg_file_fwd_if
  import defines_pkg::*;
#(
  parameter int ADDR_WD = REG_ADDR_WD,
  parameter int DATA_WD = REG_DATA_WD,
  parameter int NFWD    = NUM_FWD
);

  logic                    rd_valid;
  logic [ADDR_WD-1:0]      ra_addr;
  logic [ADDR_WD-1:0]      rb_addr;
  logic [ADDR_WD-1:0]      rc_addr;

  logic                    ev_wr_en;
  logic [ADDR_WD-1:0]      ev_wr_addr;
  logic [DATA_WD-1:0]      ev_wr_data;
  logic                    od_wr_en;
  logic [ADDR_WD-1:0]      od_wr_addr;
  logic [DATA_WD-1:0]      od_wr_data;

  logic [NFWD-1:0]         ev_fwd_vld;
  logic [NFWD*ADDR_WD-1:0] ev_fwd_addr;
  logic [NFWD*DATA_WD-1:0] ev_fwd_data;
  logic [NFWD-1:0]         od_fwd_vld;
  logic [NFWD*ADDR_WD-1:0] od_fwd_addr;
  logic [NFWD*DATA_WD-1:0] od_fwd_data;

  logic [DATA_WD-1:0]      out_RA;
  logic [DATA_WD-1:0]      out_RB;
  logic [DATA_WD-1:0]      out_RC;
  logic                    out_vld;
  logic                    wr_collision;

  modport master (
    output rd_valid, ra_addr, rb_addr, rc_addr,
    output ev_wr_en, ev_wr_addr, ev_wr_data,
    output od_wr_en, od_wr_addr, od_wr_data,
    output ev_fwd_vld, ev_fwd_addr, ev_fwd_data,
    output od_fwd_vld, od_fwd_addr, od_fwd_data,
    input  out_RA, out_RB, out_RC, out_vld, wr_collision
  );

  modport slave (
    input  rd_valid, ra_addr, rb_addr, rc_addr,
    input  ev_wr_en, ev_wr_addr, ev_wr_data,
    input  od_wr_en, od_wr_addr, od_wr_data,
    input  ev_fwd_vld, ev_fwd_addr, ev_fwd_data,
    input  od_fwd_vld, od_fwd_addr, od_fwd_data,
    output out_RA, out_RB, out_RC, out_vld, wr_collision
  );

endinterface

// File: rtl/reg_file_fwd_fwd_mux.sv
// fwd_mux
// Combinational operand resolver for one source address.
// Priority, highest first: forwarding s2..s7 (odd beats even within a stage),
// then same-cycle write ports (odd beats even), then the array read data.
// Ports:
//   addr                      operand address
//   ev_/od_fwd_vld/addr/data  forwarding stages, slice 0 = s2
//   ev_/od_wr_en/addr/data    writeback ports (write-first bypass)
//   arr_data                  array contents at addr
//   data_out                  resolved operand
module fwd_mux #(
  parameter int REG_ADDR_WD = defines_pkg::REG_ADDR_WD,
  parameter int REG_DATA_WD = defines_pkg::REG_DATA_WD,
  parameter int NUM_FWD     = defines_pkg::NUM_FWD
) (
  input  logic [REG_ADDR_WD-1:0]         addr,
  input  logic [NUM_FWD-1:0]             ev_fwd_vld,
  input  logic [NUM_FWD*REG_ADDR_WD-1:0] ev_fwd_addr,
  input  logic [NUM_FWD*REG_DATA_WD-1:0] ev_fwd_data,
  input  logic [NUM_FWD-1:0]             od_fwd_vld,
  input  logic [NUM_FWD*REG_ADDR_WD-1:0] od_fwd_addr,
  input  logic [NUM_FWD*REG_DATA_WD-1:0] od_fwd_data,
  input  logic                           ev_wr_en,
  input  logic [REG_ADDR_WD-1:0]         ev_wr_addr,
  input  logic [REG_DATA_WD-1:0]         ev_wr_data,
  input  logic                           od_wr_en,
  input  logic [REG_ADDR_WD-1:0]         od_wr_addr,
  input  logic [REG_DATA_WD-1:0]         od_wr_data,
  input  logic [REG_DATA_WD-1:0]         arr_data,
  output logic [REG_DATA_WD-1:0]         data_out
);

  // Sources are applied lowest priority first so each later match overrides;
  // stages are walked from s7 down to s2 so the youngest stage wins last.
  always_comb begin
    data_out = arr_data;
    if (ev_wr_en && (ev_wr_addr == addr)) data_out = ev_wr_data;
    if (od_wr_en && (od_wr_addr == addr)) data_out = od_wr_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (ev_fwd_vld[i] && (ev_fwd_addr[i*REG_ADDR_WD +: REG_ADDR_WD] == addr))
        data_out = ev_fwd_data[i*REG_DATA_WD +: REG_DATA_WD];
      if (od_fwd_vld[i] && (od_fwd_addr[i*REG_ADDR_WD +: REG_ADDR_WD] == addr))
        data_out = od_fwd_data[i*REG_DATA_WD +: REG_DATA_WD];
    end
  end

endmodule

// File: rtl/reg_file_fwd.sv
// reg_file_fwd
// Dual-write, triple-read register file with per-operand forwarding from
// both execution pipes. Operands resolve combinationally and register with a
// fixed one-cycle latency; there is no stall or hazard detection.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset (clears array and all outputs)
//   bus   reg_file_fwd_if.slave: requests, writebacks, forwarding, results
module reg_file_fwd #(
  parameter int REG_ADDR_WD = defines_pkg::REG_ADDR_WD,
  parameter int REG_DATA_WD = defines_pkg::REG_DATA_WD,
  parameter int NUM_FWD     = defines_pkg::NUM_FWD
) (
  input  logic           clk,
  input  logic           rst,
  reg_file_fwd_if.slave  bus
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WD;

  logic [REG_DATA_WD-1:0] mem [NUM_REGS];

  logic [REG_DATA_WD-1:0] res_a, res_b, res_c;
  logic [REG_DATA_WD-1:0] out_a_q, out_b_q, out_c_q;
  logic                   out_vld_q;
  logic                   wr_coll_q;
  logic                   coll_now;

  assign coll_now = bus.ev_wr_en && bus.od_wr_en &&
                    (bus.ev_wr_addr == bus.od_wr_addr);

  fwd_mux #(
    .REG_ADDR_WD(REG_ADDR_WD), .REG_DATA_WD(REG_DATA_WD), .NUM_FWD(NUM_FWD)
  ) u_mux_a (
    .addr(bus.ra_addr),
    .ev_fwd_vld(bus.ev_fwd_vld), .ev_fwd_addr(bus.ev_fwd_addr), .ev_fwd_data(bus.ev_fwd_data),
    .od_fwd_vld(bus.od_fwd_vld), .od_fwd_addr(bus.od_fwd_addr), .od_fwd_data(bus.od_fwd_data),
    .ev_wr_en(bus.ev_wr_en), .ev_wr_addr(bus.ev_wr_addr), .ev_wr_data(bus.ev_wr_data),
    .od_wr_en(bus.od_wr_en), .od_wr_addr(bus.od_wr_addr), .od_wr_data(bus.od_wr_data),
    .arr_data(mem[bus.ra_addr]),
    .data_out(res_a)
  );

  fwd_mux #(
    .REG_ADDR_WD(REG_ADDR_WD), .REG_DATA_WD(REG_DATA_WD), .NUM_FWD(NUM_FWD)
  ) u_mux_b (
    .addr(bus.rb_addr),
    .ev_fwd_vld(bus.ev_fwd_vld), .ev_fwd_addr(bus.ev_fwd_addr), .ev_fwd_data(bus.ev_fwd_data),
    .od_fwd_vld(bus.od_fwd_vld), .od_fwd_addr(bus.od_fwd_addr), .od_fwd_data(bus.od_fwd_data),
    .ev_wr_en(bus.ev_wr_en), .ev_wr_addr(bus.ev_wr_addr), .ev_wr_data(bus.ev_wr_data),
    .od_wr_en(bus.od_wr_en), .od_wr_addr(bus.od_wr_addr), .od_wr_data(bus.od_wr_data),
    .arr_data(mem[bus.rb_addr]),
    .data_out(res_b)
  );

  fwd_mux #(
    .REG_ADDR_WD(REG_ADDR_WD), .REG_DATA_WD(REG_DATA_WD), .NUM_FWD(NUM_FWD)
  ) u_mux_c (
    .addr(bus.rc_addr),
    .ev_fwd_vld(bus.ev_fwd_vld), .ev_fwd_addr(bus.ev_fwd_addr), .ev_fwd_data(bus.ev_fwd_data),
    .od_fwd_vld(bus.od_fwd_vld), .od_fwd_addr(bus.od_fwd_addr), .od_fwd_data(bus.od_fwd_data),
    .ev_wr_en(bus.ev_wr_en), .ev_wr_addr(bus.ev_wr_addr), .ev_wr_data(bus.ev_wr_data),
    .od_wr_en(bus.od_wr_en), .od_wr_addr(bus.od_wr_addr), .od_wr_data(bus.od_wr_data),
    .arr_data(mem[bus.rc_addr]),
    .data_out(res_c)
  );

  // Odd write is issued after even so it wins a same-address dual write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[REG_ADDR_WD'(i)] <= '0;
    end else begin
      if (bus.ev_wr_en) mem[bus.ev_wr_addr] <= bus.ev_wr_data;
      if (bus.od_wr_en) mem[bus.od_wr_addr] <= bus.od_wr_data;
    end
  end

  // Operand registers only load on a request so they hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_c_q   <= '0;
      out_vld_q <= 1'b0;
      wr_coll_q <= 1'b0;
    end else begin
      out_vld_q <= bus.rd_valid;
      wr_coll_q <= coll_now;
      if (bus.rd_valid) begin
        out_a_q <= res_a;
        out_b_q <= res_b;
        out_c_q <= res_c;
      end
    end
  end

  assign bus.out_RA       = out_a_q;
  assign bus.out_RB       = out_b_q;
  assign bus.out_RC       = out_c_q;
  assign bus.out_vld      = out_vld_q;
  assign bus.wr_collision = wr_coll_q;

endmodule

// File: tb/tb_reg_file_fwd.sv
module tb_reg_file_fwd;
  import defines_pkg::*;

  localparam int AW = REG_ADDR_WD;
  localparam int DW = REG_DATA_WD;
  localparam int NF = NUM_FWD;

  localparam logic [DW-1:0] D_AA = {16{8'hAA}};
  localparam logic [DW-1:0] D_55 = {16{8'h55}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_fwd_if bus ();

  reg_file_fwd dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string            name;
    logic             rd;
    logic [AW-1:0]    ra, rb, rc;
    logic             ewe, owe;
    logic [AW-1:0]    ewa, owa;
    logic [DW-1:0]    ewd, owd;
    logic [NF-1:0]    efv, ofv;
    logic [NF*AW-1:0] efa, ofa;
    logic [NF*DW-1:0] efd, ofd;
    logic             xv;
    logic [DW-1:0]    xa, xb, xc;
    logic             xcoll;
  } vec_t;

  typedef struct {
    string         name;
    logic          vld;
    logic [DW-1:0] a, b, c;
    logic          coll;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t blank(string nm);
    vec_t v;
    v.name = nm; v.rd = 1'b0; v.ra = '0; v.rb = '0; v.rc = '0;
    v.ewe = 1'b0; v.owe = 1'b0; v.ewa = '0; v.owa = '0; v.ewd = '0; v.owd = '0;
    v.efv = '0; v.ofv = '0; v.efa = '0; v.ofa = '0; v.efd = '0; v.ofd = '0;
    v.xv = 1'b0; v.xa = '0; v.xb = '0; v.xc = '0; v.xcoll = 1'b0;
    return v;
  endfunction

  task automatic chk_bit(string nm, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, req);
    end
  endtask

  task automatic chk_dat(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic drive(vec_t v);
    bus.rd_valid = v.rd;
    bus.ra_addr = v.ra; bus.rb_addr = v.rb; bus.rc_addr = v.rc;
    bus.ev_wr_en = v.ewe; bus.ev_wr_addr = v.ewa; bus.ev_wr_data = v.ewd;
    bus.od_wr_en = v.owe; bus.od_wr_addr = v.owa; bus.od_wr_data = v.owd;
    bus.ev_fwd_vld = v.efv; bus.ev_fwd_addr = v.efa; bus.ev_fwd_data = v.efd;
    bus.od_fwd_vld = v.ofv; bus.od_fwd_addr = v.ofa; bus.od_fwd_data = v.ofd;
  endtask

  task automatic push_exp(vec_t v);
    exp_t e;
    e.name = v.name; e.vld = v.xv; e.a = v.xa; e.b = v.xb; e.c = v.xc; e.coll = v.xcoll;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      chk_bit({e.name, ".out_vld"}, bus.out_vld, e.vld);
      chk_dat({e.name, ".out_RA"}, bus.out_RA, e.a);
      chk_dat({e.name, ".out_RB"}, bus.out_RB, e.b);
      chk_dat({e.name, ".out_RC"}, bus.out_RC, e.c);
      chk_bit({e.name, ".wr_collision"}, bus.wr_collision, e.coll);
    end
  endtask

  // Drive one cycle of stimulus, record expectation, sample 1 time unit after the edge.
  task automatic step(vec_t v);
    drive(v);
    push_exp(v);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;

    // ---------------- vector table ----------------
    vecs[0] = blank("rd_after_reset");
    vecs[0].rd = 1; vecs[0].ra = 5; vecs[0].rb = 0; vecs[0].rc = 127; vecs[0].xv = 1;

    vecs[1] = blank("ev_write_10");
    vecs[1].ewe = 1; vecs[1].ewa = 10; vecs[1].ewd = D_AA;

    vecs[2] = blank("read_10");
    vecs[2].rd = 1; vecs[2].ra = 10; vecs[2].xv = 1; vecs[2].xa = D_AA;

    vecs[3] = blank("bypass_10");
    vecs[3].rd = 1; vecs[3].ra = 10; vecs[3].rb = 10; vecs[3].rc = 10;
    vecs[3].ewe = 1; vecs[3].ewa = 10; vecs[3].ewd = D_55;
    vecs[3].xv = 1; vecs[3].xa = D_55; vecs[3].xb = D_55; vecs[3].xc = D_55;

    vecs[4] = blank("od_write_3");
    vecs[4].owe = 1; vecs[4].owa = 3; vecs[4].owd = 1;
    vecs[4].xa = D_55; vecs[4].xb = D_55; vecs[4].xc = D_55;

    vecs[5] = blank("fwd_s2_over_s4");
    vecs[5].rd = 1; vecs[5].ra = 3; vecs[5].rb = 3; vecs[5].rc = 10;
    vecs[5].efv[2] = 1; vecs[5].efa[2*AW +: AW] = 3; vecs[5].efd[2*DW +: DW] = 4;
    vecs[5].ofv[0] = 1; vecs[5].ofa[0 +: AW] = 3;    vecs[5].ofd[0 +: DW] = 2;
    vecs[5].xv = 1; vecs[5].xa = 2; vecs[5].xb = 2; vecs[5].xc = D_55;

    vecs[6] = blank("fwd_s4_when_s2_invalid");
    vecs[6].rd = 1; vecs[6].ra = 3; vecs[6].rb = 3; vecs[6].rc = 4;
    vecs[6].efv[2] = 1; vecs[6].efa[2*AW +: AW] = 3; vecs[6].efd[2*DW +: DW] = 4;
    vecs[6].ofv[0] = 0; vecs[6].ofa[0 +: AW] = 3;    vecs[6].ofd[0 +: DW] = 'hDEAD;
    vecs[6].efv[5] = 1; vecs[6].efa[5*AW +: AW] = 4; vecs[6].efd[5*DW +: DW] = 9;
    vecs[6].ofv[3] = 1; vecs[6].ofa[3*AW +: AW] = 4; vecs[6].ofd[3*DW +: DW] = 'hC;
    vecs[6].xv = 1; vecs[6].xa = 4; vecs[6].xb = 4; vecs[6].xc = 'hC;

    vecs[7] = blank("odd_beats_even");
    vecs[7].rd = 1; vecs[7].ra = 20; vecs[7].rb = 21; vecs[7].rc = 3;
    vecs[7].efv[1] = 1; vecs[7].efa[1*AW +: AW] = 20; vecs[7].efd[1*DW +: DW] = 'h33;
    vecs[7].ofv[1] = 1; vecs[7].ofa[1*AW +: AW] = 20; vecs[7].ofd[1*DW +: DW] = 'h44;
    vecs[7].ewe = 1; vecs[7].ewa = 21; vecs[7].ewd = 'h77;
    vecs[7].owe = 1; vecs[7].owa = 21; vecs[7].owd = 'h66;
    vecs[7].xv = 1; vecs[7].xa = 'h44; vecs[7].xb = 'h66; vecs[7].xc = 1; vecs[7].xcoll = 1;

    vecs[8] = blank("idle_hold");
    vecs[8].xa = 'h44; vecs[8].xb = 'h66; vecs[8].xc = 1;

    vecs[9] = blank("dual_write_7");
    vecs[9].ewe = 1; vecs[9].ewa = 7; vecs[9].ewd = 'h11;
    vecs[9].owe = 1; vecs[9].owa = 7; vecs[9].owd = 'h22;
    vecs[9].xa = 'h44; vecs[9].xb = 'h66; vecs[9].xc = 1; vecs[9].xcoll = 1;

    vecs[10] = blank("read_7_21_10");
    vecs[10].rd = 1; vecs[10].ra = 7; vecs[10].rb = 21; vecs[10].rc = 10;
    vecs[10].xv = 1; vecs[10].xa = 'h22; vecs[10].xb = 'h66; vecs[10].xc = D_55;

    vecs[11] = blank("fwd_beats_bypass");
    vecs[11].rd = 1; vecs[11].ra = 10; vecs[11].rb = 10; vecs[11].rc = 20;
    vecs[11].ewe = 1; vecs[11].ewa = 10; vecs[11].ewd = D_AA;
    vecs[11].ofv[4] = 1; vecs[11].ofa[4*AW +: AW] = 10; vecs[11].ofd[4*DW +: DW] = 'hBB;
    vecs[11].xv = 1; vecs[11].xa = 'hBB; vecs[11].xb = 'hBB; vecs[11].xc = 0;

    vecs[12] = blank("burst_1");
    vecs[12].rd = 1; vecs[12].rc = 10; vecs[12].xv = 1; vecs[12].xc = D_AA;
    vecs[13] = blank("burst_2");
    vecs[13].rd = 1; vecs[13].rc = 7;  vecs[13].xv = 1; vecs[13].xc = 'h22;
    vecs[14] = blank("burst_3");
    vecs[14].rd = 1; vecs[14].rc = 21; vecs[14].xv = 1; vecs[14].xc = 'h66;
    vecs[15] = blank("burst_end_hold");
    vecs[15].xc = 'h66;

    // ---------------- reset state ----------------
    rst = 1'b0;
    drive(blank("idle"));
    repeat (2) @(posedge clk);
    #1;
    chk_bit("reset.out_vld", bus.out_vld, 1'b0);
    chk_dat("reset.out_RA", bus.out_RA, '0);
    chk_dat("reset.out_RB", bus.out_RB, '0);
    chk_dat("reset.out_RC", bus.out_RC, '0);
    chk_bit("reset.wr_collision", bus.wr_collision, 1'b0);
    rst = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < 16; i++) step(vecs[i]);

    // ---------------- reset mid-stream ----------------
    v = blank("pre_reset_read");
    v.rd = 1; v.ra = 10; v.rb = 7; v.rc = 21;
    v.xv = 1; v.xa = D_AA; v.xb = 'h22; v.xc = 'h66;
    step(v);

    v.xa = '0; v.xb = '0; v.xc = '0; v.xv = 1'b0;
    drive(v);
    #3;
    rst = 1'b0;
    #1;
    chk_bit("async_rst.out_vld", bus.out_vld, 1'b0);
    chk_dat("async_rst.out_RA", bus.out_RA, '0);
    chk_dat("async_rst.out_RB", bus.out_RB, '0);
    chk_dat("async_rst.out_RC", bus.out_RC, '0);
    chk_bit("async_rst.wr_collision", bus.wr_collision, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_bit("post_release.out_vld", bus.out_vld, 1'b0);

    v = blank("read_after_reset");
    v.rd = 1; v.ra = 10; v.rb = 7; v.rc = 21; v.xv = 1;
    step(v);

    v = blank("bypass_after_reset");
    v.rd = 1; v.ra = 10; v.rb = 7; v.rc = 3;
    v.ewe = 1; v.ewa = 10; v.ewd = 'h5A;
    v.xv = 1; v.xa = 'h5A; v.xb = 0; v.xc = 0;
    step(v);

    v = blank("final_idle");
    v.xa = 'h5A;
    step(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_fwd.md
REG_FILE_FWD -- requirements
Module: reg_file_fwd

Interface
REQ-001 Parameter REG_ADDR_WD, default 7, register address width.
REQ-002 Parameter REG_DATA_WD, default 128, register data width.
REQ-003 Parameter NUM_FWD, default 6, forwarding stages per pipe (s2..s7).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rd_valid  input  1  operand read request this cycle.
REQ-007 ra_addr, rb_addr, rc_addr  input  7 each  source register addresses.
REQ-008 ev_wr_en, od_wr_en  input  1 each  even/odd pipe writeback enable.
REQ-009 ev_wr_addr, od_wr_addr  input  7 each  writeback target address.
REQ-010 ev_wr_data, od_wr_data  input  128 each  writeback data.
REQ-011 ev_fwd_vld, od_fwd_vld  input  NUM_FWD each  per-stage result valid; bit 0 = s2, bit 5 = s7.
REQ-012 ev_fwd_addr, od_fwd_addr  input  NUM_FWD x 7 packed  per-stage target address.
REQ-013 ev_fwd_data, od_fwd_data  input  NUM_FWD x 128 packed  per-stage result data.
REQ-014 out_RA, out_RB, out_RC  output  128 each  resolved operands.
REQ-015 out_vld  output  1  operands valid.
REQ-016 wr_collision  output  1  both write ports targeted the same address in the previous cycle.

Function
REQ-017 Storage: 128 entries x 128 bits; writes take effect at the rising clk edge when the port's wr_en=1.
REQ-018 Same-cycle dual write to one address: the odd port's data is stored; wr_collision=1 for exactly the following cycle.
REQ-019 Read latency: exactly 1 cycle; operands resolved in cycle N with rd_valid=1 appear on out_RA/RB/RC with out_vld=1 in cycle N+1.
REQ-020 rd_valid=0: out_vld=0 next cycle; out_RA/RB/RC hold their last values.
REQ-021 Per-operand resolution priority, highest first: forwarding stage s2..s7 in ascending stage order; within one stage the odd pipe beats the even pipe; then the same-cycle write ports (odd before even); then the array contents.
REQ-022 A forwarding entry matches only when its vld bit=1 and its addr equals the operand address; data on invalid stages is ignored.
REQ-023 Read-during-write to the same address: the new write data is returned (write-first bypass) unless a higher-priority forwarding entry matches.
REQ-024 Operands resolve independently; identical ra/rb/rc addresses return identical data.
REQ-025 No stall, back-pressure, or hazard detection is performed; every request completes in 1 cycle.

Reset
REQ-026 rst low asynchronously clears all 128 entries, out_RA/RB/RC, out_vld and wr_collision to 0.
REQ-027 Reset asserted mid-read: the pending out_vld is discarded, with no output in the cycle after release.
REQ-028 Reads in the first cycle after release return 0 unless forwarded or bypassed.

Structure
REQ-029 REG_ADDR_WD, REG_DATA_WD and NUM_FWD live in defines_pkg.
REQ-030 A sub-module fwd_mux implements the REQ-021 priority for one operand; it is instantiated 3 times.
REQ-031 fwd_mux is purely combinational; all registers reside in reg_file_fwd.

Verification
REQ-032 Reset, then rd_valid with ra=5 -> next cycle out_RA=0, out_vld=1.
REQ-033 ev_wr_en, addr 10, data 0xAA..AA; next cycle read ra=10 -> out_RA=0xAA..AA; same-cycle write and read of addr 10 with data 0x55..55 -> out_RA=0x55..55.
REQ-034 Array r3=1; even s4 addr 3 data 4; odd s2 addr 3 data 2; read rb=3 -> out_RB=2; drop odd s2 vld -> out_RB=4.
REQ-035 Even and odd write addr 7 with data 0x11 and 0x22 in the same cycle -> wr_collision=1 for one cycle; later read of addr 7 -> 0x22.
REQ-036 rd_valid for 3 cycles then 0 -> out_vld 1,1,1,0; out_RC holds its final value.
REQ-037 Assert rst low mid-stream with rd_valid=1 -> outputs immediately 0; after release, read of any previously written address -> 0.
